// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default dmem word-address and data widths
//   port_e                  : requester IDs (PORT_CPU = 0, PORT_LDR = 1)
//   AGE_W                   : width of the port-1 aging counter
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int AGE_W      = 8;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and dmem.
//   req/we/addr/wdata 0,1 : requester -> arbiter
//   gnt/rvalid/rdata 0,1  : arbiter -> requester
//   address_dmem/data/wren: arbiter -> dmem
//   q_dmem                : dmem -> arbiter (1-cycle read latency)
// Modport slave is the arbiter's view, master is the environment's view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q_dmem,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           address_dmem, data, wren
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q_dmem,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           address_dmem, data, wren
  );

endinterface

// File: rtl/dmem_arb_age.sv
// Starvation guard for the loader port: counts consecutive cycles in which
// port 1 requests but is denied, saturating at MAX_WAIT. When the count has
// reached MAX_WAIT and port 1 is still requesting, force_gnt tells the
// arbiter to hand the cycle to port 1.
//   clock, reset : clock, asynchronous active-high reset
//   req          : port 1 request
//   gnt          : port 1 grant this cycle (from the arbiter)
//   force_gnt    : port 1 must win this cycle
module dmem_arb_age
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic force_gnt
);

  localparam logic [AGE_W-1:0] MAX_CNT = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] wait_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!req || gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered count only, so no combinational loop through the arbiter.
  assign force_gnt = req & (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 (processor) has fixed priority; port 1 (loader) is force-granted
// after MAX_WAIT consecutive denied cycles. Grants are combinational, the
// winning port's address/data/write-enable go straight to dmem, and the
// 1-cycle read data is tagged back to the port that issued the read.
//   clock, reset : clock (shared with dmem), asynchronous active-high reset
//   bus          : requester handshakes and dmem connections (slave modport)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  logic              force_gnt;
  logic              gnt0_c, gnt1_c;
  logic              rd_grant;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              rd_pend;
  port_e             rd_owner;

  dmem_arb_age #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clock     (clock),
    .reset     (reset),
    .req       (bus.req1),
    .gnt       (gnt1_c),
    .force_gnt (force_gnt)
  );

  // Stage 0: grant decision and dmem request mux (same cycle as req).
  always_comb begin
    gnt1_c   = ~reset & bus.req1 & (~bus.req0 | force_gnt);
    gnt0_c   = ~reset & bus.req0 & ~gnt1_c;
    rd_grant = (gnt0_c & ~bus.we0) | (gnt1_c & ~bus.we1);
    // Idle falls through to port 0 so dmem inputs stay deterministic.
    addr_mux = gnt1_c ? bus.addr1  : bus.addr0;
    data_mux = gnt1_c ? bus.wdata1 : bus.wdata0;
  end

  assign bus.gnt0         = gnt0_c;
  assign bus.gnt1         = gnt1_c;
  assign bus.address_dmem = addr_mux;
  assign bus.data         = data_mux;
  assign bus.wren         = (gnt0_c & bus.we0) | (gnt1_c & bus.we1);

  // Stage 1: read-return tracking, aligned with dmem's registered q_dmem.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= PORT_CPU;
    end else begin
      rd_pend <= rd_grant;
      if (rd_grant) begin
        rd_owner <= gnt1_c ? PORT_LDR : PORT_CPU;
      end
    end
  end

  assign bus.rvalid0 = rd_pend & (rd_owner == PORT_CPU);
  assign bus.rvalid1 = rd_pend & (rd_owner == PORT_LDR);
  assign bus.rdata0  = bus.q_dmem;
  assign bus.rdata1  = bus.q_dmem;

endmodule
